// File: rtl/bch_pkg.sv
// Shared constants and per-code tables for the t=2 BCH encoder/decoder pair.
// Generators are m1(x)*m3(x) over GF(2^6), GF(2^8) and GF(2^10).
package bch_pkg;

  typedef enum logic [1:0] {
    CODE_NONE = 2'd0,
    CODE_63   = 2'd1,
    CODE_255  = 2'd2,
    CODE_1023 = 2'd3
  } code_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } enc_state_e;

  localparam logic [12:0] G63   = 13'h1539;
  localparam logic [16:0] G255  = 17'h16f63;
  localparam logic [20:0] G1023 = 21'h101877;

  function automatic logic [9:0] n_len(code_e c);
    case (c)
      CODE_63:  return 10'd63;
      CODE_255: return 10'd255;
      default:  return 10'd1023;
    endcase
  endfunction

  function automatic logic [9:0] k_len(code_e c);
    case (c)
      CODE_63:  return 10'd51;
      CODE_255: return 10'd239;
      default:  return 10'd1003;
    endcase
  endfunction

  function automatic logic [4:0] par_len(code_e c);
    case (c)
      CODE_63:  return 5'd12;
      CODE_255: return 5'd16;
      default:  return 5'd20;
    endcase
  endfunction

  function automatic logic [4:0] words(code_e c);
    case (c)
      CODE_63:  return 5'd1;
      CODE_255: return 5'd4;
      default:  return 5'd16;
    endcase
  endfunction

  function automatic logic [6:0] tail_bits(code_e c);
    case (c)
      CODE_63:  return 7'd51;
      CODE_255: return 7'd47;
      default:  return 7'd43;
    endcase
  endfunction

  // Generator without its leading term, right-aligned in the LFSR width.
  function automatic logic [19:0] gpoly(code_e c);
    case (c)
      CODE_63:  return 20'(G63[11:0]);
      CODE_255: return 20'(G255[15:0]);
      default:  return G1023[19:0];
    endcase
  endfunction

  function automatic logic [19:0] lfsr_mask(code_e c);
    case (c)
      CODE_63:  return 20'h00fff;
      CODE_255: return 20'h0ffff;
      default:  return 20'hfffff;
    endcase
  endfunction

  // Parity plus pad positions in the final word.
  function automatic logic [63:0] par_field(code_e c);
    case (c)
      CODE_63:  return 64'h1fff;
      CODE_255: return 64'h1ffff;
      default:  return 64'h1fffff;
    endcase
  endfunction

endpackage

// File: rtl/bch_enc_lfsr.sv
// Combinational multi-bit step of the systematic BCH parity LFSR.
// Consumes nbits message bits from data, MSB first.
module bch_enc_lfsr
  import bch_pkg::*;
(
  input  logic [19:0] state,
  input  logic [63:0] data,
  input  logic [6:0]  nbits,
  input  logic [1:0]  code,
  output logic [19:0] next
);

  logic [19:0] r;
  logic [19:0] g;
  logic [19:0] msk;
  logic [4:0]  p;
  logic        fb;

  always_comb begin
    p   = par_len(code_e'(code));
    g   = gpoly(code_e'(code));
    msk = lfsr_mask(code_e'(code));
    r   = state;
    fb  = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i < int'(nbits)) begin
        fb = data[63-i] ^ r[p-5'd1];
        r  = ((r << 1) ^ (fb ? g : 20'd0)) & msk;
      end
    end
    next = r;
  end

endmodule

// File: rtl/bch_enc.sv
// Streaming systematic t=2 BCH encoder, one 64-bit word per cycle.
// Define BCH_ENC_ERRINJ_EN to add the inj_mask error-injection port.
module bch_enc
  import bch_pkg::*;
#(
  parameter int WORDS_MAX = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  code,
  input  logic        set,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
`ifdef BCH_ENC_ERRINJ_EN
  input  logic [63:0] inj_mask,
`endif
  output logic        finish
);

  localparam int CW = $clog2(WORDS_MAX);

  enc_state_e    state_q;
  enc_state_e    state_d;
  code_e         code_q;
  logic [19:0]   lfsr_q;
  logic [19:0]   lfsr_d;
  logic [CW-1:0] wcnt_q;
  logic          start;
  logic          accept;
  logic          is_last;
  logic          last_hs;
  logic [6:0]    nbits;
  logic [63:0]   word;
  logic [63:0]   inj;

`ifdef BCH_ENC_ERRINJ_EN
  assign inj = inj_mask;
`else
  assign inj = '0;
`endif

  assign start    = (state_q == S_IDLE) && set && (code != 2'd0);
  assign in_ready = (state_q == S_RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_last  = (wcnt_q == CW'(words(code_q) - 5'd1));
  assign nbits    = is_last ? tail_bits(code_q) : 7'd64;
  assign last_hs  = (state_q == S_DRAIN) && out_valid && out_ready;

  bch_enc_lfsr u_lfsr (
    .state (lfsr_q),
    .data  (in_data),
    .nbits (nbits),
    .code  (code_q),
    .next  (lfsr_d)
  );

  // Final word: keep the tail message, splice parity above a zero pad.
  always_comb begin
    word = in_data;
    if (is_last)
      word = (in_data & ~par_field(code_q)) | (64'(lfsr_d) << 1);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (accept && is_last) state_d = S_DRAIN;
      S_DRAIN: if (last_hs) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      code_q    <= CODE_63;
      lfsr_q    <= '0;
      wcnt_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      finish    <= 1'b0;
    end else begin
      finish <= last_hs;
      if (start) begin
        code_q <= code_e'(code);
        lfsr_q <= '0;
        wcnt_q <= '0;
      end else if (accept) begin
        lfsr_q <= lfsr_d;
        wcnt_q <= is_last ? '0 : wcnt_q + 1'b1;
      end
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= word ^ inj;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bch_enc.sv
// Directed bench for bch_enc: hand vectors, backpressure, chaining, reset.
// Codewords are also checked for divisibility by g(x) via long division.
module tb_bch_enc;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [1:0]  code = 2'd0;
  logic        set = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        finish;
  logic [63:0] inj = '0;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] msg [16];
  logic [63:0] got [16];
  int nout, fin_cyc, hs_cyc, acc_cyc, val_cyc;

  always #5 clk = ~clk;

  bch_enc dut (
    .clk       (clk),
    .rstn      (rstn),
    .code      (code),
    .set       (set),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
`ifdef BCH_ENC_ERRINJ_EN
    .inj_mask  (inj),
`endif
    .finish    (finish)
  );

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Remainder of the whole received codeword modulo the full g(x).
  function automatic logic [63:0] cw_rem(input logic [1:0] c, input int nw,
                                         input logic [63:0] m);
    logic [20:0] r, g;
    logic [63:0] w;
    int p;
    p = (c == 2'd1) ? 12 : (c == 2'd2) ? 16 : 20;
    g = (c == 2'd1) ? 21'h001539 : (c == 2'd2) ? 21'h016f63 : 21'h101877;
    r = '0;
    for (int i = 0; i < nw; i++) begin
      w = got[i] ^ m;
      for (int b = 63; b >= 0; b--) begin
        if (!(i == nw - 1 && b == 0)) begin
          r = {r[19:0], w[b]};
          if (r[p]) r = r ^ g;
        end
      end
    end
    return 64'(r);
  endfunction

  task automatic do_set(input logic [1:0] c);
    set = 1'b1;
    code = c;
    @(posedge clk);
    @(negedge clk);
    set = 1'b0;
    code = 2'd0;
  endtask

  // Feed msg[0..nw-1], collect into got[]; nxt!=0 re-arms in the finish cycle.
  task automatic run_cw(input int nw, input bit bp, input logic [1:0] nxt);
    int sent, cyc;
    bit done, held;
    logic [63:0] hold;
    sent = 0; cyc = 0; done = 0; held = 0; hold = '0;
    nout = 0; acc_cyc = -1; val_cyc = -1; hs_cyc = -1; fin_cyc = -1;
    while (!done && cyc < 400) begin
      in_valid = (sent < nw);
      if (sent < nw) in_data = msg[sent];
      else in_data = '0;
      out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      #1;
      if (held) check("stall_hold", out_data, hold);
      if (finish) begin
        done = 1;
        fin_cyc = cyc;
        if (nxt != 2'd0) begin
          set = 1'b1;
          code = nxt;
        end
      end
      if (out_valid && val_cyc < 0) val_cyc = cyc;
      if (out_valid && out_ready) begin
        if (nout < 16) got[nout] = out_data;
        nout++;
        hs_cyc = cyc;
      end
      if (in_valid && in_ready) begin
        if (acc_cyc < 0) acc_cyc = cyc;
        sent++;
      end
      held = out_valid && !out_ready;
      hold = out_data;
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    set = 1'b0;
    code = 2'd0;
    check("finish_seen", 64'(done), 64'd1);
    check("finish_pulse", 64'(finish), 64'd0);
    check("first_latency", 64'(val_cyc), 64'(acc_cyc + 1));
    check("finish_timing", 64'(fin_cyc), 64'(hs_cyc + 1));
  endtask

  task automatic chk_words(input logic [1:0] c, input int nw,
                           input logic [63:0] m);
    int p;
    logic [63:0] fld;
    p = (c == 2'd1) ? 12 : (c == 2'd2) ? 16 : 20;
    fld = (64'd1 << (p + 1)) - 64'd1;
    check("word_count", 64'(nout), 64'(nw));
    for (int i = 0; i < nw - 1; i++)
      check($sformatf("pass_w%0d", i), got[i] ^ m, msg[i]);
    check("msg_tail", (got[nw-1] ^ m) & ~fld, msg[nw-1] & ~fld);
    check("pad_bit", (got[nw-1] ^ m) & 64'd1, 64'd0);
    check("syndrome", cw_rem(c, nw, m), 64'd0);
  endtask

  initial begin
    #1 rstn = 1'b0;
    #2;
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_finish", 64'(finish), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Illegal code: FSM must stay idle
    do_set(2'd0);
    in_valid = 1'b1;
    in_data = 64'h1234;
    #1;
    check("illegal_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("illegal_out_valid", 64'(out_valid), 64'd0);
    check("illegal_in_ready2", 64'(in_ready), 64'd0);
    in_valid = 1'b0;

    // Code 1 hand vectors
    do_set(2'd1);
    msg[0] = 64'h0;
    run_cw(1, 0, 2'd0);
    check("c1_zero", got[0], 64'h0);

    do_set(2'd1);
    msg[0] = 64'h2000;
    run_cw(1, 0, 2'd0);
    check("c1_x12", got[0], 64'h2a72);

    do_set(2'd1);
    msg[0] = 64'h4000;
    run_cw(1, 0, 2'd0);
    check("c1_x13", got[0], 64'h54e4);

    do_set(2'd1);
    msg[0] = 64'h3fff;
    run_cw(1, 0, 2'd0);
    check("c1_dontcare", got[0], 64'h2a72);

    do_set(2'd1);
    msg[0] = 64'hffff_ffff_ffff_ffff;
    run_cw(1, 0, 2'd0);
    chk_words(2'd1, 1, 64'd0);

    // Code 2 lowest message bit
    for (int i = 0; i < 4; i++) msg[i] = 64'h0;
    msg[3] = 64'h20000;
    do_set(2'd2);
    run_cw(4, 0, 2'd0);
    check("c2_w0", got[0], 64'h0);
    check("c2_x16", got[3], 64'h2dec6);

    // Code 3 lowest message bit
    for (int i = 0; i < 16; i++) msg[i] = 64'h0;
    msg[15] = 64'h200000;
    do_set(2'd3);
    run_cw(16, 0, 2'd0);
    check("c3_w0", got[0], 64'h0);
    check("c3_x20", got[15], 64'h2030ee);

    // Code 3 random under backpressure
    for (int i = 0; i < 16; i++) msg[i] = {$urandom, $urandom};
    do_set(2'd3);
    run_cw(16, 1, 2'd0);
    chk_words(2'd3, 16, 64'd0);

    // Back-to-back: code 2 then code 1, re-armed in the finish cycle
    for (int i = 0; i < 4; i++) msg[i] = {$urandom, $urandom};
    do_set(2'd2);
    run_cw(4, 0, 2'd1);
    chk_words(2'd2, 4, 64'd0);
    msg[0] = {$urandom, $urandom};
    run_cw(1, 0, 2'd0);
    chk_words(2'd1, 1, 64'd0);

    // Reset after word 2 of a code 3 codeword
    msg[0] = {$urandom, $urandom};
    msg[1] = {$urandom, $urandom};
    do_set(2'd3);
    out_ready = 1'b1;
    in_valid = 1'b1;
    in_data = msg[0];
    @(posedge clk);
    @(negedge clk);
    in_data = msg[1];
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_valid", 64'(out_valid), 64'd1);
    rstn = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_out_data", out_data, 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    check("abort_finish", 64'(finish), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    in_valid = 1'b1;
    #1;
    check("post_rst_idle", 64'(in_ready), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    do_set(2'd1);
    msg[0] = 64'h2000;
    run_cw(1, 0, 2'd0);
    check("post_rst_c1", got[0], 64'h2a72);

`ifdef BCH_ENC_ERRINJ_EN
    inj = (64'd1 << 40) | (64'd1 << 5);
    for (int i = 0; i < 4; i++) msg[i] = {$urandom, $urandom};
    do_set(2'd2);
    run_cw(4, 0, 2'd0);
    chk_words(2'd2, 4, inj);
    inj = '0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
